// File: rtl/rom_fetch_arbiter_pkg.sv
// rom_arb_pkg: shared types and constants for the ROM fetch/load arbiter.
//   owner_e : which requester owns the single in-flight ROM read
//   SZ_*    : load size encodings (3 is reserved and handled as a word)
package rom_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/rom_fetch_arbiter_load_extend.sv
// load_extend: purely combinational byte/half/word extraction and extension.
// The word already starts at the requested byte, so only the low bytes are
// kept and the remaining bits are filled with zero or the sign bit.
//   word        in  32  raw data word
//   size        in  2   SZ_B / SZ_H / SZ_W (3 behaves as word)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 32  extended data
module load_extend
  import rom_arb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic is_byte;
  logic is_word;
  logic fill;

  assign is_byte = (size == SZ_B);
  assign is_word = (size == SZ_W) || (size == 2'd3);
  // Sign source is bit 15 for halves, bit 7 otherwise (unused for words).
  assign fill    = !is_unsigned && ((size == SZ_H) ? word[15] : word[7]);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      if (gi < 8) begin : g_low
        assign result[gi] = word[gi];
      end else if (gi < 16) begin : g_mid
        assign result[gi] = is_byte ? fill : word[gi];
      end else begin : g_high
        assign result[gi] = is_word ? word[gi] : fill;
      end
    end
  endgenerate

endmodule

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares the single synchronous read port of the program
// ROM between instruction fetch and the load unit. Round-robin arbitration,
// one grant per cycle, response returned to the owner one cycle later.
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr/if_flush    fetch request, byte address, response kill
//   if_gnt/if_rvalid/if_rdata/if_err   fetch grant and response
//   ld_req/ld_addr/ld_size/ld_unsigned load request
//   ld_gnt/ld_rvalid/ld_rdata          load grant and extended response
//   rom_addr/rom_data          ROM address out, ROM data in (1-cycle latency)
module rom_fetch_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  output logic                  if_err,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [1:0]            ld_size,
  input  logic                  ld_unsigned,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [31:0]           ld_rdata,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_data
);

  owner_e     owner_reg, owner_next;
  owner_e     last_reg, last_next;
  logic [1:0] ld_size_reg;
  logic       ld_unsigned_reg;
  logic       if_mis_reg;
  logic       if_win;
  logic       ld_win;
  logic [31:0] ld_ext;

  // Arbitration: a lone requester wins; on conflict the one not granted
  // last time wins.
  always_comb begin
    if_win     = if_req && (!ld_req || (last_reg == OWN_LD));
    ld_win     = ld_req && !if_win;
    owner_next = OWN_NONE;
    last_next  = last_reg;
    if (if_win) begin
      owner_next = OWN_IF;
      last_next  = OWN_IF;
    end else if (ld_win) begin
      owner_next = OWN_LD;
      last_next  = OWN_LD;
    end
  end

  // Grants are masked while reset is held so nothing looks accepted.
  assign if_gnt = rst_n && if_win;
  assign ld_gnt = rst_n && ld_win;

  always_comb begin
    rom_addr = '0;
    if (if_gnt) begin
      rom_addr = if_addr;
    end else if (ld_gnt) begin
      rom_addr = ld_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg       <= OWN_NONE;
      last_reg        <= OWN_LD;
      ld_size_reg     <= SZ_B;
      ld_unsigned_reg <= 1'b0;
      if_mis_reg      <= 1'b0;
    end else begin
      owner_reg <= owner_next;
      last_reg  <= last_next;
      if (ld_win) begin
        ld_size_reg     <= ld_size;
        ld_unsigned_reg <= ld_unsigned;
      end
      if (if_win) begin
        if_mis_reg <= |if_addr[1:0];
      end
    end
  end

  load_extend u_load_extend (
    .word        (rom_data),
    .size        (ld_size_reg),
    .is_unsigned (ld_unsigned_reg),
    .result      (ld_ext)
  );

  // Flush only hides the fetch response; the ROM read still completed.
  assign if_rvalid = (owner_reg == OWN_IF) && !if_flush;
  assign if_rdata  = if_rvalid ? rom_data : 32'd0;
  assign if_err    = if_rvalid && if_mis_reg;

  assign ld_rvalid = (owner_reg == OWN_LD);
  assign ld_rdata  = ld_rvalid ? ld_ext : 32'd0;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Testbench for rom_fetch_arbiter: directed scenarios followed by random
// traffic. A byte-array ROM model feeds the DUT; expected responses are
// queued at grant time and checked by an independent monitor.
module tb_rom_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ld_req = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [1:0]  ld_size = '0;
  logic        ld_unsigned = 1'b0;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic [11:0] rom_addr;
  logic [31:0] rom_data = '0;

  rom_fetch_arbiter #(.ADDR_WIDTH(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_flush    (if_flush),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .if_err      (if_err),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_size     (ld_size),
    .ld_unsigned (ld_unsigned),
    .ld_gnt      (ld_gnt),
    .ld_rvalid   (ld_rvalid),
    .ld_rdata    (ld_rdata),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data)
  );

  always #5 clk = ~clk;

  // ROM model: byte array, word = 4 bytes starting at the address, wrapping.
  logic [7:0] mem [0:4095];

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    logic [11:0] a1, a2, a3;
    a1 = a + 12'd1;
    a2 = a + 12'd2;
    a3 = a + 12'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  // Reference load result from size/signedness rules.
  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] sz,
                                           input logic u);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] sx;
    b = w[7:0];
    h = w[15:0];
    case (sz)
      2'd0: begin
        sx = $signed(b);
        return u ? {24'd0, b} : sx;
      end
      2'd1: begin
        sx = $signed(h);
        return u ? {16'd0, h} : sx;
      end
      default: return w;
    endcase
  endfunction

  typedef struct {
    int          due;
    logic [11:0] addr;
    logic [31:0] data;
    logic        err;
    logic        flush;
  } rsp_t;

  rsp_t if_q[$];
  rsp_t ld_q[$];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   m_last = 1;          // 0 = fetch granted last, 1 = load granted last
  logic flush_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // One bus cycle: drive requests, check grants/address, queue expectations.
  // fl = kill the fetch response that would appear in the following cycle.
  task automatic step(input logic ir, input logic [11:0] ia, input logic lr,
                      input logic [11:0] la, input logic [1:0] ls, input logic lu,
                      input logic fl, output logic g_if, output logic g_ld);
    logic [11:0] exp_addr;
    @(posedge clk);
    #1;
    if_req      = ir;
    if_addr     = ia;
    ld_req      = lr;
    ld_addr     = la;
    ld_size     = ls;
    ld_unsigned = lu;
    if_flush    = flush_pending;
    @(negedge clk);
    g_if = ir && (!lr || (m_last == 1));
    g_ld = lr && !g_if;
    exp_addr = g_if ? ia : (g_ld ? la : 12'd0);
    check("if_gnt", 32'(if_gnt), 32'(g_if));
    check("ld_gnt", 32'(ld_gnt), 32'(g_ld));
    check("rom_addr", 32'(rom_addr), 32'(exp_addr));
    if (g_if) begin
      m_last = 0;
      if_q.push_back('{due: cyc + 1, addr: ia, data: rom_word(ia),
                       err: (ia[1:0] != 2'd0), flush: fl});
    end
    if (g_ld) begin
      m_last = 1;
      ld_q.push_back('{due: cyc + 1, addr: la, data: ld_model(rom_word(la), ls, lu),
                       err: 1'b0, flush: 1'b0});
    end
    flush_pending = fl;
  endtask

  // Monitor: compares every cycle's response outputs against the queues.
  always @(negedge clk) begin
    rsp_t e;
    while (if_q.size() > 0 && if_q[0].due < cyc) begin
      e = if_q.pop_front();
      check("if_missed_rsp", 32'(e.addr), 32'hFFFF_FFFF);
    end
    while (ld_q.size() > 0 && ld_q[0].due < cyc) begin
      e = ld_q.pop_front();
      check("ld_missed_rsp", 32'(e.addr), 32'hFFFF_FFFF);
    end
    if (if_q.size() > 0 && if_q[0].due == cyc) begin
      e = if_q.pop_front();
      check("if_rvalid", 32'(if_rvalid), 32'(!e.flush));
      check("if_rdata", if_rdata, e.flush ? 32'd0 : e.data);
      check("if_err", 32'(if_err), 32'(!e.flush && e.err));
      $display("cycle %0d IF rsp addr=0x%03h data=0x%08h err=%0b flushed=%0b",
               cyc, e.addr, if_rdata, if_err, e.flush);
    end else begin
      check("if_rvalid_idle", 32'(if_rvalid), 32'd0);
      check("if_rdata_idle", if_rdata, 32'd0);
      check("if_err_idle", 32'(if_err), 32'd0);
    end
    if (ld_q.size() > 0 && ld_q[0].due == cyc) begin
      e = ld_q.pop_front();
      check("ld_rvalid", 32'(ld_rvalid), 32'd1);
      check("ld_rdata", ld_rdata, e.data);
      $display("cycle %0d LD rsp addr=0x%03h data=0x%08h", cyc, e.addr, ld_rdata);
    end else begin
      check("ld_rvalid_idle", 32'(ld_rvalid), 32'd0);
      check("ld_rdata_idle", ld_rdata, 32'd0);
    end
  end

  logic        gi, gl;
  logic        pi, pl, plu, fl;
  logic [11:0] pia, pla;
  logic [1:0]  pls;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h020] = 8'h80;
    mem[12'h021] = 8'hFF;
    mem[12'h022] = 8'h12;
    mem[12'h023] = 8'h34;

    // Power-on reset: outputs quiet even with requests pending.
    if_req = 1'b1;
    ld_req = 1'b1;
    if_addr = 12'h123;
    ld_addr = 12'h456;
    @(negedge clk);
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_ld_gnt", 32'(ld_gnt), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    if_req = 1'b0;
    ld_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fetch only, three cycles at 0x010.
    for (int i = 0; i < 3; i++) step(1, 12'h010, 0, 12'h000, 2'd0, 0, 0, gi, gl);
    step(0, 12'h000, 0, 12'h000, 2'd0, 0, 0, gi, gl);

    // Load extension on bytes 80 FF 12 34 at 0x020.
    step(0, 12'h000, 1, 12'h020, 2'd0, 0, 0, gi, gl);
    step(0, 12'h000, 1, 12'h020, 2'd0, 1, 0, gi, gl);
    step(0, 12'h000, 1, 12'h020, 2'd1, 0, 0, gi, gl);
    step(0, 12'h000, 1, 12'h020, 2'd2, 0, 0, gi, gl);

    // Conflict: last winner was the load, so IF, LD, IF, LD.
    for (int i = 0; i < 4; i++) step(1, 12'h040, 1, 12'h044, 2'd2, 0, 0, gi, gl);
    step(0, 12'h000, 0, 12'h000, 2'd0, 0, 0, gi, gl);

    // Misaligned fetch, then a flushed fetch followed by a normal one.
    step(1, 12'h006, 0, 12'h000, 2'd0, 0, 0, gi, gl);
    step(1, 12'h100, 0, 12'h000, 2'd0, 0, 1, gi, gl);
    step(1, 12'h104, 0, 12'h000, 2'd0, 0, 0, gi, gl);
    step(0, 12'h000, 0, 12'h000, 2'd0, 0, 0, gi, gl);

    // Reset right after a load grant: that response must never appear.
    step(0, 12'h000, 1, 12'h030, 2'd2, 0, 0, gi, gl);
    #1;
    rst_n = 1'b0;
    if_q.delete();
    ld_q.delete();
    m_last = 1;
    flush_pending = 1'b0;
    if_flush = 1'b0;
    if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_if_gnt", 32'(if_gnt), 32'd0);
      check("midrst_ld_gnt", 32'(ld_gnt), 32'd0);
      check("midrst_rom_addr", 32'(rom_addr), 32'd0);
    end
    if_req = 1'b0;
    ld_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 12'h050, 1, 12'h054, 2'd2, 0, 0, gi, gl);
    check("post_rst_first_is_if", 32'(gi), 32'd1);
    step(0, 12'h000, 0, 12'h000, 2'd0, 0, 0, gi, gl);

    // Random traffic; requests held with a stable address until granted.
    pi = 0; pl = 0; pia = '0; pla = '0; pls = '0; plu = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pi && $urandom_range(0, 2) != 0) begin
        pi = 1;
        pia = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 3) != 0) pia[1:0] = 2'b00;
      end
      if (!pl && $urandom_range(0, 2) != 0) begin
        pl = 1;
        pla = 12'($urandom_range(0, 4095));
        pls = 2'($urandom_range(0, 3));
        plu = 1'($urandom_range(0, 1));
      end
      fl = ($urandom_range(0, 4) == 0);
      step(pi, pia, pl, pla, pls, plu, fl, gi, gl);
      if (gi) pi = 0;
      if (gl) pl = 0;
    end

    step(0, 12'h000, 0, 12'h000, 2'd0, 0, 0, gi, gl);
    step(0, 12'h000, 0, 12'h000, 2'd0, 0, 0, gi, gl);
    check("queues_drained", 32'(if_q.size() + ld_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
